// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU control codes, MIPS opcode/funct
// constants and the registered issue payload.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned IMM_W   = 16;

  typedef enum logic [CTRL_W-1:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_ORI   = 4'b0100,
    ALU_ADDIU = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_ADDI  = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SLT   = 4'b1001,
    ALU_LUI   = 4'b1111
  } alu_ctrl_e;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

  localparam logic [OPC_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OPC_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OPC_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OPC_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OPC_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OPC_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OPC_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [OPC_W-1:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic             valid;
    alu_ctrl_e        alu_ctrl;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [REG_W-1:0] shamt;
    logic             reg_write;
    logic [REG_W-1:0] dst_reg;
    logic             illegal;
  } issue_t;

  localparam issue_t ISSUE_BUBBLE = '0;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: instruction word plus operand values to an issue payload.
// Undecodable words produce a valid bubble flagged illegal.
module alu_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output issue_t          issue_c
);

  logic [OPC_W-1:0] opcode;
  logic [OPC_W-1:0] funct;
  logic [REG_W-1:0] rt_idx;
  logic [REG_W-1:0] rd_idx;
  logic [XLEN-1:0]  imm_sext;
  logic [XLEN-1:0]  imm_zext;
  logic             unused_rs_idx;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rt_idx   = instr[20:16];
  assign rd_idx   = instr[15:11];
  assign imm_sext = {{(XLEN-IMM_W){instr[15]}}, instr[15:0]};
  assign imm_zext = {{(XLEN-IMM_W){1'b0}}, instr[15:0]};
  // rs arrives already resolved as rs_data; its index is not needed here
  assign unused_rs_idx = ^instr[25:21];

  alu_ctrl_e        ctrl;
  logic [XLEN-1:0]  a_val;
  logic [XLEN-1:0]  b_val;
  logic [REG_W-1:0] dst;
  logic             wr;
  logic             legal;

  always_comb begin
    ctrl  = ALU_AND;
    a_val = rs_data;
    b_val = rt_data;
    dst   = rd_idx;
    wr    = 1'b0;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        wr = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl = ALU_ADD;
          FN_SUB:          ctrl = ALU_SUB;
          FN_AND:          ctrl = ALU_AND;
          FN_OR:           ctrl = ALU_OR;
          FN_XOR:          ctrl = ALU_XOR;
          FN_SLT:          ctrl = ALU_SLT;
          FN_SLL: begin
            ctrl  = ALU_SLL;
            a_val = rt_data;
            b_val = '0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin ctrl = ALU_ADDI;  b_val = imm_sext; dst = rt_idx; wr = 1'b1; end
      OP_ADDIU: begin ctrl = ALU_ADDIU; b_val = imm_sext; dst = rt_idx; wr = 1'b1; end
      OP_ORI:   begin ctrl = ALU_ORI;   b_val = imm_zext; dst = rt_idx; wr = 1'b1; end
      OP_LUI:   begin ctrl = ALU_LUI;   b_val = imm_zext; dst = rt_idx; wr = 1'b1; end
      OP_LW:    begin ctrl = ALU_ADD;   b_val = imm_sext; dst = rt_idx; wr = 1'b1; end
      OP_SW:    begin ctrl = ALU_ADD;   b_val = imm_sext; dst = rt_idx; end
      OP_BEQ:   begin ctrl = ALU_SUB;   b_val = rt_data;  dst = rt_idx; end
      default:  legal = 1'b0;
    endcase

    issue_c       = ISSUE_BUBBLE;
    issue_c.valid = 1'b1;
    if (legal) begin
      issue_c.alu_ctrl  = ctrl;
      issue_c.alu_a     = a_val;
      issue_c.alu_b     = b_val;
      issue_c.shamt     = instr[10:6];
      issue_c.dst_reg   = dst;
      // $0 is hardwired, so a write to it is never a real write-back
      issue_c.reg_write = wr && (dst != '0);
    end else begin
      issue_c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes one instruction per cycle and holds the result in flops,
// with reset > flush > stall > new-instruction priority.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       instr,
  input  logic [XLEN-1:0]       rs_data,
  input  logic [XLEN-1:0]       rt_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [CTRL_W-1:0]     alu_ctrl,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [REG_W-1:0]      shamt,
  output logic                  reg_write,
  output logic [REG_W-1:0]      dst_reg,
  output logic                  illegal
);

  issue_t dec_c;
  issue_t issue_d;
  issue_t issue_q;

  alu_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .issue_c (dec_c)
  );

  always_comb begin
    issue_d = issue_q;
    if (flush) begin
      issue_d = ISSUE_BUBBLE;
    end else if (stall) begin
      issue_d = issue_q;
    end else if (in_valid) begin
      issue_d = dec_c;
    end else begin
      issue_d = ISSUE_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= ISSUE_BUBBLE;
    end else begin
      issue_q <= issue_d;
    end
  end

  assign out_valid = issue_q.valid;
  assign alu_ctrl  = issue_q.alu_ctrl;
  assign alu_a     = issue_q.alu_a;
  assign alu_b     = issue_q.alu_b;
  assign shamt     = issue_q.shamt;
  assign reg_write = issue_q.reg_write;
  assign dst_reg   = issue_q.dst_reg;
  assign illegal   = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-encoded MIPS words with hand-computed results.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic        reg_write;
  logic [4:0]  dst_reg;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .shamt     (shamt),
    .reg_write (reg_write),
    .dst_reg   (dst_reg),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // apply inputs, then sample 1 time unit after the capturing edge
  task automatic cyc(input logic v, input logic [31:0] ins, a, b,
                     input logic st, input logic fl, input logic r);
    in_valid = v; instr = ins; rs_data = a; rt_data = b;
    stall = st; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] c,
                            input logic [31:0] a, b, input logic [4:0] sh, input logic chk_sh,
                            input logic wr, input logic [4:0] dst, input logic ill);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".ctrl"},  32'(alu_ctrl),  32'(c));
    check({tag, ".a"},     alu_a, a);
    check({tag, ".b"},     alu_b, b);
    if (chk_sh) check({tag, ".shamt"}, 32'(shamt), 32'(sh));
    check({tag, ".wr"},    32'(reg_write), 32'(wr));
    check({tag, ".dst"},   32'(dst_reg),   32'(dst));
    check({tag, ".ill"},   32'(illegal),   32'(ill));
  endtask

  task automatic expect_bubble(input string tag);
    expect_out(tag, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  logic [31:0] add_w;

  initial begin
    add_w = r_type(5'd1, 5'd2, 5'd10, 5'd0, 6'b100000);
    in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    stall = 1'b0; flush = 1'b0; rst = 1'b1;

    // reset with a valid add presented: instruction is lost
    cyc(1'b1, add_w, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
    expect_bubble("reset");

    // addi $5,$4,-1
    cyc(1'b1, i_type(6'b001000, 5'd4, 5'd5, 16'hFFFF), 32'h10, 32'h99, 1'b0, 1'b0, 1'b0);
    expect_out("addi", 1'b1, 4'b0111, 32'h10, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);

    // ori $3,$0,0x8000 (zero-extended)
    cyc(1'b1, i_type(6'b001101, 5'd0, 5'd3, 16'h8000), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("ori", 1'b1, 4'b0100, 32'h0, 32'h0000_8000, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);

    // lui $2,0x1234
    cyc(1'b1, i_type(6'b001111, 5'd0, 5'd2, 16'h1234), 32'h55, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("lui", 1'b1, 4'b1111, 32'h55, 32'h0000_1234, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);

    // addiu $6,$1,0x8001 (sign-extended)
    cyc(1'b1, i_type(6'b001001, 5'd1, 5'd6, 16'h8001), 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("addiu", 1'b1, 4'b0101, 32'h20, 32'hFFFF_8001, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);

    // sll $8,$9,4
    cyc(1'b1, r_type(5'd0, 5'd9, 5'd8, 5'd4, 6'b000000), 32'hAAAA, 32'h3, 1'b0, 1'b0, 1'b0);
    expect_out("sll", 1'b1, 4'b1000, 32'h3, 32'h0, 5'd4, 1'b1, 1'b1, 5'd8, 1'b0);

    // add $10,$1,$2 then three stalled cycles with different instructions
    cyc(1'b1, add_w, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    expect_out("add", 1'b1, 4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0);
    cyc(1'b1, r_type(5'd3, 5'd4, 5'd11, 5'd0, 6'b100010), 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    expect_out("stall1", 1'b1, 4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0);
    cyc(1'b1, i_type(6'b001111, 5'd0, 5'd2, 16'h1234), 32'h3, 32'h4, 1'b1, 1'b0, 1'b0);
    expect_out("stall2", 1'b1, 4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0);
    cyc(1'b0, 32'hFFFF_FFFF, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0);
    expect_out("stall3", 1'b1, 4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0);

    // stall together with flush: flush wins
    cyc(1'b1, add_w, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    expect_bubble("stall_flush");

    // sub with rd=$0: write-back suppressed
    cyc(1'b1, r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'b100010), 32'd9, 32'd4, 1'b0, 1'b0, 1'b0);
    expect_out("sub_r0", 1'b1, 4'b0110, 32'd9, 32'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);

    // slt / and / or / xor, addu
    cyc(1'b1, r_type(5'd1, 5'd2, 5'd12, 5'd0, 6'b101010), 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
    expect_out("slt", 1'b1, 4'b1001, 32'h11, 32'h22, 5'd0, 1'b1, 1'b1, 5'd12, 1'b0);
    cyc(1'b1, r_type(5'd1, 5'd2, 5'd13, 5'd0, 6'b100100), 32'hF0, 32'h0F, 1'b0, 1'b0, 1'b0);
    expect_out("and", 1'b1, 4'b0000, 32'hF0, 32'h0F, 5'd0, 1'b1, 1'b1, 5'd13, 1'b0);
    cyc(1'b1, r_type(5'd1, 5'd2, 5'd14, 5'd0, 6'b100101), 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    expect_out("or", 1'b1, 4'b0001, 32'h1, 32'h2, 5'd0, 1'b1, 1'b1, 5'd14, 1'b0);
    cyc(1'b1, r_type(5'd1, 5'd2, 5'd15, 5'd0, 6'b100110), 32'h3, 32'h5, 1'b0, 1'b0, 1'b0);
    expect_out("xor", 1'b1, 4'b0011, 32'h3, 32'h5, 5'd0, 1'b1, 1'b1, 5'd15, 1'b0);
    cyc(1'b1, r_type(5'd1, 5'd2, 5'd16, 5'd0, 6'b100001), 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);
    expect_out("addu", 1'b1, 4'b0010, 32'h7, 32'h8, 5'd0, 1'b1, 1'b1, 5'd16, 1'b0);

    // lw $7,-4($6) and sw $7,8($6)
    cyc(1'b1, i_type(6'b100011, 5'd6, 5'd7, 16'hFFFC), 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("lw", 1'b1, 4'b0010, 32'h100, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    cyc(1'b1, i_type(6'b101011, 5'd6, 5'd7, 16'h0008), 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("sw", 1'b1, 4'b0010, 32'h100, 32'h8, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0);

    // beq $1,$2: compares rs_data with rt_data
    cyc(1'b1, i_type(6'b000100, 5'd1, 5'd2, 16'h0010), 32'h44, 32'h45, 1'b0, 1'b0, 1'b0);
    expect_out("beq", 1'b1, 4'b0110, 32'h44, 32'h45, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0);

    // all-zero word is sll $0,$0,0: valid, no write-back
    cyc(1'b1, 32'h0, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0);
    expect_out("nop", 1'b1, 4'b1000, 32'h34, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);

    // in_valid low without stall
    cyc(1'b0, add_w, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    expect_bubble("idle");

    // plain flush of a valid instruction
    cyc(1'b1, add_w, 32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
    expect_bubble("flush");

    // undecodable funct (jr) under opcode 000000
    cyc(1'b1, r_type(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000), 32'h5, 32'h6, 1'b0, 1'b0, 1'b0);
    expect_out("bad_funct", 1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);

    // opcode 111111
    cyc(1'b1, 32'hFC00_0000 | 32'h0022_1800, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0);
    expect_out("bad_op", 1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);

    // reset with a valid add, stall and flush asserted: all zero
    cyc(1'b1, add_w, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
    expect_bubble("rst_add");

    // first edge after reset captures the instruction
    cyc(1'b1, add_w, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    expect_out("post_rst", 1'b1, 4'b0010, 32'd5, 32'd7, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
